// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keypad operand entry block.
package kb_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam logic [1:0] OP_ENTER = 2'b00;
  localparam logic [1:0] OP_PLUS  = 2'b01;
  localparam logic [1:0] OP_MINUS = 2'b10;

  typedef enum logic [1:0] {
    ST_MAKE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kb_state_e;

endpackage

// File: rtl/kb_entry_ctrl_if.sv
// Scan-byte input and operand-token handshake between receiver, entry block and consumer.
interface kb_entry_ctrl_if;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        tok_valid;
  logic        tok_ready;
  logic [15:0] tok_value;
  logic [2:0]  tok_ndig;
  logic [1:0]  tok_op;

  modport master (
    input  scan_code, scan_valid, tok_ready,
    output tok_valid, tok_value, tok_ndig, tok_op
  );

  modport slave (
    output scan_code, scan_valid, tok_ready,
    input  tok_valid, tok_value, tok_ndig, tok_op
  );
endinterface

// File: rtl/kb_scan_decode.sv
// Combinational make-code classifier. Backspace (0x66) is recognised only
// when KB_BACKSPACE_EN is defined; otherwise it is ignored like other codes.
module kb_scan_decode
  import kb_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_term,
  output logic [1:0] op,
  output logic       is_bksp
);

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    unique case (scan_code)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    is_term = 1'b1;
    op      = OP_ENTER;
    unique case (scan_code)
      SC_ENTER: op = OP_ENTER;
      SC_PLUS:  op = OP_PLUS;
      SC_MINUS: op = OP_MINUS;
      default:  is_term = 1'b0;
    endcase
  end

`ifdef KB_BACKSPACE_EN
  assign is_bksp = (scan_code == SC_BKSP);
`else
  assign is_bksp = 1'b0;
`endif

endmodule

// File: rtl/kb_entry_ctrl.sv
// PS/2 keypad operand entry: strips break/extended prefixes, accumulates BCD
// digits and emits one operand token per terminator through a valid/ready register.
module kb_entry_ctrl
  import kb_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  kb_entry_ctrl_if.master bus,
  input  logic            err_clr,
  output logic            err_ovf,
  output logic            err_ovr
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  kb_state_e   state, state_nxt;
  logic        proc_make, proc_ext_enter;
  logic        dec_is_digit, dec_is_term, dec_is_bksp;
  logic [3:0]  dec_digit;
  logic [1:0]  dec_op;
  logic        do_digit, do_term, do_bksp;
  logic [1:0]  term_op;
  logic        accept, tok_load, ovf_set, ovr_set;

  logic [15:0] acc;
  logic [2:0]  cnt;
  logic        tok_valid;
  logic [15:0] tok_value;
  logic [2:0]  tok_ndig;
  logic [1:0]  tok_op;

  kb_scan_decode u_decode (
    .scan_code (bus.scan_code),
    .is_digit  (dec_is_digit),
    .digit     (dec_digit),
    .is_term   (dec_is_term),
    .op        (dec_op),
    .is_bksp   (dec_is_bksp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_MAKE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    proc_make      = 1'b0;
    proc_ext_enter = 1'b0;
    if (bus.scan_valid) begin
      unique case (state)
        ST_MAKE: begin
          if (bus.scan_code == SC_BRK)      state_nxt = ST_BRK;
          else if (bus.scan_code == SC_EXT) state_nxt = ST_EXT;
          else                              proc_make = 1'b1;
        end
        ST_EXT: begin
          if (bus.scan_code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            state_nxt      = ST_MAKE;
            proc_ext_enter = (bus.scan_code == SC_ENTER);
          end
        end
        default: state_nxt = ST_MAKE;
      endcase
    end
  end

  // Keypad Enter arrives as E0 5A and always terminates with the Enter op.
  assign do_digit = proc_make && dec_is_digit;
  assign do_bksp  = proc_make && dec_is_bksp;
  assign do_term  = (proc_make && dec_is_term) || proc_ext_enter;
  assign term_op  = proc_ext_enter ? OP_ENTER : dec_op;

  assign accept   = tok_valid && bus.tok_ready;
  assign tok_load = do_term && (!tok_valid || accept);
  assign ovr_set  = do_term && tok_valid && !accept;
  assign ovf_set  = do_digit && (cnt >= MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (do_term) begin
      acc <= '0;
      cnt <= '0;
    end else if (do_digit && (cnt < MAX_CNT)) begin
      acc <= {acc[11:0], dec_digit};
      cnt <= cnt + 3'd1;
    end else if (do_bksp && (cnt != 3'd0)) begin
      acc <= acc >> 4;
      cnt <= cnt - 3'd1;
    end
  end

  // A terminator that finds the register occupied is dropped; the old token stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_valid <= 1'b0;
      tok_value <= '0;
      tok_ndig  <= '0;
      tok_op    <= OP_ENTER;
    end else if (tok_load) begin
      tok_valid <= 1'b1;
      tok_value <= acc;
      tok_ndig  <= cnt;
      tok_op    <= term_op;
    end else if (accept) begin
      tok_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_ovr <= 1'b0;
    end else if (err_clr) begin
      err_ovf <= 1'b0;
      err_ovr <= 1'b0;
    end else begin
      err_ovf <= err_ovf | ovf_set;
      err_ovr <= err_ovr | ovr_set;
    end
  end

  assign bus.tok_valid = tok_valid;
  assign bus.tok_value = tok_value;
  assign bus.tok_ndig  = tok_ndig;
  assign bus.tok_op    = tok_op;

endmodule

// File: doc/kb_entry_ctrl.md
KB_ENTRY_CTRL -- requirements
Module: kb_entry_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, maximum number of decimal digits per operand (1..4).
REQ-002 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port scan_code  in  8  PS/2 scan byte from the receiver.
REQ-005 SHALL have port scan_valid  in  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-006 SHALL have port tok_valid  out  1  operand token pending.
REQ-007 SHALL have port tok_ready  in  1  consumer accepts the token when tok_valid && tok_ready.
REQ-008 SHALL have port tok_value  out  16  operand as packed BCD; the least significant nibble holds the last digit entered.
REQ-009 SHALL have port tok_ndig  out  3  number of digits in the token (0..MAX_DIGITS).
REQ-010 SHALL have port tok_op  out  2  terminator: 00 Enter, 01 plus (0x79), 10 minus (0x7B).
REQ-011 SHALL have port err_ovf  out  1  sticky flag: a digit was dropped because the operand already held MAX_DIGITS digits.
REQ-012 SHALL have port err_ovr  out  1  sticky flag: a token was lost because the output register was full.
REQ-013 SHALL have port err_clr  in  1  synchronous clear of both error flags.

Function
REQ-014 SHALL decode make codes to digits as follows: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
REQ-015 SHALL treat 0x79 (plus), 0x7B (minus) and 0x5A (Enter) as terminators, and SHALL ignore all other codes.
REQ-016 SHALL implement a prefix FSM with states MAKE, BRK, EXT and EXT_BRK, advancing only on scan_valid.
- MAKE: 0xF0 -> BRK; 0xE0 -> EXT; any other code is processed and the FSM stays in MAKE.
- BRK: the next byte is discarded -> MAKE.
- EXT: 0xF0 -> EXT_BRK; 0x5A is processed as Enter -> MAKE; any other byte is discarded -> MAKE.
- EXT_BRK: the next byte is discarded -> MAKE.
REQ-017 SHALL accept a digit as follows: acc = {acc[11:0], digit} and cnt += 1, provided cnt < MAX_DIGITS.
REQ-018 SHALL drop a digit that arrives when cnt == MAX_DIGITS, and SHALL set err_ovf in that case.
REQ-019 SHALL, on a terminator, load the token register with acc, cnt and the op code, and SHALL clear acc and cnt to 0 in the same cycle.
REQ-020 SHALL assert tok_valid in the cycle after the terminating scan_valid and hold it until accepted.
REQ-021 SHALL hold tok_value, tok_ndig and tok_op stable while tok_valid=1 and tok_ready=0.
REQ-022 SHALL deassert tok_valid in the cycle after acceptance unless a new token loads in that cycle.
REQ-023 SHALL, when a terminator arrives while a token is pending and not accepted in that cycle, keep the old token, drop the new one, clear acc and cnt, and set err_ovr.
REQ-024 SHALL, when acceptance and a new terminator occur in the same cycle, load the new token with tok_valid staying 1 and SHALL NOT set err_ovr.
REQ-025 SHALL allow a terminator with cnt=0, producing tok_ndig=0 and tok_value=0.
REQ-026 SHALL continue digit entry while a token is pending.
REQ-027 SHALL give err_clr priority over a same-cycle set event (clear wins).

Reset
REQ-028 SHALL, on rst, set FSM=MAKE, acc=0, cnt=0, tok_valid=0, tok_value=0, tok_ndig=0, tok_op=00, err_ovf=0, err_ovr=0.
REQ-029 SHALL discard a partially entered operand and any pending token on reset, with no token emitted after release.

Configuration
REQ-030 SHALL, with KB_BACKSPACE_EN defined, treat make code 0x66 as backspace: if cnt>0 then acc = acc>>4 and cnt -= 1, otherwise no effect.
REQ-031 SHALL, without KB_BACKSPACE_EN, ignore 0x66 like any other unlisted code.

Structure
REQ-032 SHALL place scan-code constants (F0, E0, 5A, 79, 7B, 66), the tok_op encodings and the FSM state type in the shared package kb_pkg.
REQ-033 SHALL use one combinational sub-module, kb_scan_decode, mapping scan_code to {is_digit, digit[3:0], is_term, op[1:0], is_bksp}.

Verification
REQ-034 Digit entry with plus: 16,F0,16,1E,F0,1E,79,F0,79 with tok_ready=1 -> one token: value 0x0012, ndig 2, op 01.
REQ-035 Digit overflow: digits 1,2,3,4,5 then 5A -> value 0x1234, ndig 4, op 00, err_ovf=1.
REQ-036 Backspace: 16,66,1E,26,7B with KB_BACKSPACE_EN -> value 0x0023, op 10; without the macro -> value 0x0123.
REQ-037 Output stall: tok_ready=0, then 16,5A,1E,5A -> token held at 0x0001, err_ovr=1; raising tok_ready yields exactly one token.
REQ-038 Extended and break codes: E0,F0,5A then E0,16 -> no token; followed by 16 then E0,5A -> value 0x0001, op 00.
REQ-039 Reset mid-entry: 16,1E, assert rst, release, then 5A -> value 0x0000, ndig 0.
